// File: rtl/uart_receiver_if.sv
// Signal bundle between the UART receive stage (master) and the byte consumer (slave).
interface uart_receiver_if;
    logic       data_in_rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_ongoing;
    logic       frame_err;
    logic       parity_err;

    modport master (
        input  data_in_rx,
        output data_out,
        output rx_valid,
        output rx_ongoing,
        output frame_err,
        output parity_err
    );

    modport slave (
        output data_in_rx,
        input  data_out,
        input  rx_valid,
        input  rx_ongoing,
        input  frame_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 by default, 8E1 with even-parity checking when
// UART_RX_PARITY_EN is defined. Samples each bit at its midpoint, LSB first.
module uart_receiver #(
    parameter int unsigned clock_per_bit = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_receiver_if.master rx_if
);

    localparam logic [15:0] FULL_M1 = 16'(clock_per_bit - 1);
    localparam logic [15:0] HALF_M1 = 16'((clock_per_bit / 2) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY  = 3'd5,
`endif
        CLEANUP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rxs_q, rxs_d;
    logic        rxs_prev_q, rxs_prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_ongoing_q, rx_ongoing_d;
    logic        par_bad;
`ifdef UART_RX_PARITY_EN
    logic        parity_bit_q, parity_bit_d;
    logic        parity_err_q, parity_err_d;
`endif

    // Even parity: XOR of the data bits and the received parity bit must be 0.
`ifdef UART_RX_PARITY_EN
    assign par_bad = (^shift_q) ^ parity_bit_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        sync1_d      = rx_if.data_in_rx;
        rxs_d        = sync1_q;
        rxs_prev_d   = rxs_q;
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        rx_ongoing_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d     = 16'd0;
                bit_idx_d = 3'd0;
                // Only a true falling edge starts a frame; a line stuck low never re-triggers.
                if (rxs_prev_q && !rxs_q) begin
                    state_d = START;
                end
            end

            START: begin
                rx_ongoing_d = 1'b1;
                if (cnt_q == HALF_M1) begin
                    cnt_d   = 16'd0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end

            DATA: begin
                rx_ongoing_d = 1'b1;
                if (cnt_q == FULL_M1) begin
                    cnt_d              = 16'd0;
                    shift_d[bit_idx_q] = rxs_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                rx_ongoing_d = 1'b1;
                if (cnt_q == FULL_M1) begin
                    cnt_d        = 16'd0;
                    parity_bit_d = rxs_q;
                    state_d      = STOP;
                end
            end
`endif

            STOP: begin
                rx_ongoing_d = 1'b1;
                if (cnt_q == FULL_M1) begin
                    state_d     = CLEANUP;
                    frame_err_d = !rxs_q;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad;
`endif
                    if (rxs_q && !par_bad) begin
                        data_out_d = shift_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end

            CLEANUP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The synchroniser resets to the idle (high) line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_ongoing_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rxs_q        <= rxs_d;
            rxs_prev_q   <= rxs_prev_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            rx_ongoing_q <= rx_ongoing_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.data_out   = data_out_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.rx_ongoing = rx_ongoing_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule
